// File: rtl/computer_move_generator.sv
// Purpose : autonomous tic-tac-toe opponent; snapshots the board on the computer's turn, picks win > block > centre > corner > edge, then requests the move.
// Latency : win on line i -> pc after 1+i+THINK_CYCLES edges; block on line j -> 9+j+THINK_CYCLES; heuristic -> 17+THINK_CYCLES.
// Backpressure: pc is held until the live board shows the computer mark, an opposing mark appears, or TIMEOUT cycles pass.
// Ports   : clock/reset (async, active-high); enable, game_over abort to IDLE; pos1..pos9 board cells (00 empty, 01 player, 10 computer, 11 owned-less);
//           computer_position (0..8, 4'hF outside DRIVE), pc (move request), busy, move_kind (00 none, 01 win, 10 block, 11 heuristic),
//           move_done / timeout_err one-cycle pulses.
module computer_move_generator #(
    parameter int THINK_CYCLES = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       game_over,
    input  logic [1:0] pos1,
    input  logic [1:0] pos2,
    input  logic [1:0] pos3,
    input  logic [1:0] pos4,
    input  logic [1:0] pos5,
    input  logic [1:0] pos6,
    input  logic [1:0] pos7,
    input  logic [1:0] pos8,
    input  logic [1:0] pos9,
    output logic [3:0] computer_position,
    output logic       pc,
    output logic       busy,
    output logic [1:0] move_kind,
    output logic       move_done,
    output logic       timeout_err
);
    typedef enum logic [2:0] {
        S_IDLE, S_SCAN_WIN, S_SCAN_BLOCK, S_FALLBACK, S_THINK, S_DRIVE
    } state_t;

    localparam int         CNT_MAX = (THINK_CYCLES > TIMEOUT) ? THINK_CYCLES : TIMEOUT;
    localparam int         CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [1:0] EMPTY   = 2'b00;
    localparam logic [1:0] PLAYER  = 2'b01;
    localparam logic [1:0] COMP    = 2'b10;

    // Centre first, then corners, then edges.
    localparam logic [3:0] FB_ORDER [9] = '{4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7};

    state_t           state_q;
    logic [8:0][1:0]  snap_q;
    logic [2:0]       line_q;
    logic [3:0]       sel_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       pos_q;
    logic             pc_q;
    logic             busy_q;
    logic [1:0]       kind_q;
    logic             move_done_q;
    logic             timeout_err_q;

    logic [8:0][1:0]  live;
    logic [3:0]       p_cnt;
    logic [3:0]       c_cnt;
    logic             turn;
    logic [3:0]       la, lb, lc;
    logic [1:0]       ca, cb, cc;
    logic [1:0]       want;
    logic [1:0]       n_want;
    logic             line_hit;
    logic [3:0]       hit_idx;
    logic             fb_found;
    logic [3:0]       fb_idx;
    logic [1:0]       live_sel;

    assign live = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};

    always_comb begin
        p_cnt = '0;
        c_cnt = '0;
        for (int i = 0; i < 9; i++) begin
            if (live[i] == PLAYER) p_cnt = p_cnt + 4'd1;
            if (live[i] == COMP)   c_cnt = c_cnt + 4'd1;
        end
    end

    assign turn = enable && !game_over && (p_cnt == c_cnt + 4'd1);

    // Line table: rows, columns, then the two diagonals.
    always_comb begin
        la = 4'd0; lb = 4'd1; lc = 4'd2;
        case (line_q)
            3'd0: begin la = 4'd0; lb = 4'd1; lc = 4'd2; end
            3'd1: begin la = 4'd3; lb = 4'd4; lc = 4'd5; end
            3'd2: begin la = 4'd6; lb = 4'd7; lc = 4'd8; end
            3'd3: begin la = 4'd0; lb = 4'd3; lc = 4'd6; end
            3'd4: begin la = 4'd1; lb = 4'd4; lc = 4'd7; end
            3'd5: begin la = 4'd2; lb = 4'd5; lc = 4'd8; end
            3'd6: begin la = 4'd0; lb = 4'd4; lc = 4'd8; end
            default: begin la = 4'd2; lb = 4'd4; lc = 4'd6; end
        endcase
    end

    assign ca   = snap_q[la];
    assign cb   = snap_q[lb];
    assign cc   = snap_q[lc];
    assign want = (state_q == S_SCAN_WIN) ? COMP : PLAYER;

    // Two wanted marks leave one cell; the line hits only if that cell is empty.
    always_comb begin
        n_want = {1'b0, ca == want} + {1'b0, cb == want} + {1'b0, cc == want};
        line_hit = (n_want == 2'd2) && ((ca == EMPTY) || (cb == EMPTY) || (cc == EMPTY));
        if (ca == EMPTY)      hit_idx = la;
        else if (cb == EMPTY) hit_idx = lb;
        else                  hit_idx = lc;
    end

    // Walk the priority list backwards so the highest-priority empty cell wins.
    always_comb begin
        fb_found = 1'b0;
        fb_idx   = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (snap_q[FB_ORDER[i]] == EMPTY) begin
                fb_found = 1'b1;
                fb_idx   = FB_ORDER[i];
            end
        end
    end

    assign live_sel = live[sel_q];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            snap_q        <= '0;
            line_q        <= '0;
            sel_q         <= '0;
            cnt_q         <= '0;
            pos_q         <= 4'hF;
            pc_q          <= 1'b0;
            busy_q        <= 1'b0;
            kind_q        <= 2'b00;
            move_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            move_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            if (state_q != S_IDLE && (!enable || game_over)) begin
                state_q <= S_IDLE;
                pc_q    <= 1'b0;
                pos_q   <= 4'hF;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (turn) begin
                            state_q <= S_SCAN_WIN;
                            snap_q  <= live;
                            line_q  <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_SCAN_WIN, S_SCAN_BLOCK: begin
                        if (line_hit) begin
                            sel_q   <= hit_idx;
                            kind_q  <= (state_q == S_SCAN_WIN) ? 2'b01 : 2'b10;
                            cnt_q   <= '0;
                            state_q <= S_THINK;
                        end else if (line_q == 3'd7) begin
                            line_q  <= '0;
                            state_q <= (state_q == S_SCAN_WIN) ? S_SCAN_BLOCK : S_FALLBACK;
                        end else begin
                            line_q  <= line_q + 3'd1;
                        end
                    end
                    S_FALLBACK: begin
                        if (fb_found) begin
                            sel_q   <= fb_idx;
                            kind_q  <= 2'b11;
                            cnt_q   <= '0;
                            state_q <= S_THINK;
                        end else begin
                            kind_q  <= 2'b00;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                    S_THINK: begin
                        if (cnt_q == CNT_W'(THINK_CYCLES - 1)) begin
                            cnt_q   <= '0;
                            pc_q    <= 1'b1;
                            pos_q   <= sel_q;
                            state_q <= S_DRIVE;
                        end else begin
                            cnt_q   <= cnt_q + 1'b1;
                        end
                    end
                    S_DRIVE: begin
                        if (live_sel != EMPTY || cnt_q == CNT_W'(TIMEOUT - 1)) begin
                            // Computer mark -> success; any other mark -> silent abort; else timeout.
                            move_done_q   <= (live_sel == COMP);
                            timeout_err_q <= (live_sel == EMPTY);
                            pc_q          <= 1'b0;
                            pos_q         <= 4'hF;
                            busy_q        <= 1'b0;
                            state_q       <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign computer_position = pos_q;
    assign pc                = pc_q;
    assign busy              = busy_q;
    assign move_kind         = kind_q;
    assign move_done         = move_done_q;
    assign timeout_err       = timeout_err_q;
endmodule
